// File: rtl/mfdfa_profile_pkg.sv
// Shared definitions for the MFDFA profile feeder and the downstream core.
package mfdfa_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_MAX_N  = 512;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_PRIME = 2'd1,
        ST_EMIT  = 2'd2
    } state_t;

    // Width of a sample count/index able to hold the value max_n itself.
    function automatic int cnt_w(input int max_n);
        return $clog2(max_n) + 1;
    endfunction

    // Signed profile width: N*P needs data_w+2*cw bits, plus a sign bit.
    function automatic int prof_w(input int data_w, input int cw);
        return data_w + 2 * cw + 1;
    endfunction

endpackage

// File: rtl/mfdfa_profile_buf.sv
// Series buffer: one write port, one synchronous read port, contents not reset.
module mfdfa_profile_buf #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 512,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write on demand, read every cycle with one cycle of latency.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/mfdfa_profile.sv
// Buffers one price series, then streams its N-scaled mean-removed profile.
module mfdfa_profile
    import mfdfa_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int MAX_N  = DEF_MAX_N,
    parameter int CNT_W  = cnt_w(MAX_N),
    parameter int PROF_W = prof_w(DATA_W, CNT_W)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PROF_W-1:0]       out_data,
    output logic [CNT_W-1:0]        out_index,
    output logic                    out_last,
    output logic [CNT_W-1:0]        series_n,
    output logic [DATA_W+CNT_W-1:0] series_sum,
    output logic                    err_trunc,
    output logic                    busy
);

    localparam int AW    = $clog2(MAX_N);
    localparam int SUM_W = DATA_W + CNT_W;

    state_t              state;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    idx;
    logic [SUM_W-1:0]    sum;
    logic [SUM_W-1:0]    prefix;
    logic [DATA_W-1:0]   rd_data;
    logic [AW-1:0]       rd_addr;

    logic                accept;
    logic                load_word;
    logic                done_word;
    logic [CNT_W-1:0]    count_nxt;
    logic [CNT_W-1:0]    idx_nxt;
    logic [SUM_W-1:0]    sum_nxt;
    logic [SUM_W-1:0]    prefix_nxt;
    logic [PROF_W-1:0]   word_pos;
    logic [PROF_W-1:0]   word_neg;

    mfdfa_profile_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_N),
        .AW     (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (count[AW-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Handshake decode, next-word arithmetic and the read-prefetch address.
    // rd_data always holds buf[idx]; the address steps to idx+1 only in the
    // cycle that loads the output register, so a stall re-reads the same word.
    always_comb begin
        in_ready   = (state == ST_LOAD);
        busy       = (state != ST_LOAD);
        accept     = in_valid && in_ready;
        count_nxt  = count + 1'b1;
        sum_nxt    = sum + SUM_W'(in_data);
        load_word  = (state == ST_EMIT) && (!out_valid || (out_ready && !out_last));
        done_word  = (state == ST_EMIT) && out_valid && out_ready && out_last;
        idx_nxt    = idx + 1'b1;
        prefix_nxt = prefix + SUM_W'(rd_data);
        word_pos   = PROF_W'(series_n) * PROF_W'(prefix_nxt);
        word_neg   = PROF_W'(idx_nxt) * PROF_W'(series_sum);
        rd_addr    = load_word ? idx_nxt[AW-1:0] : idx[AW-1:0];
    end

    // Control FSM: load the series, prime the read pipe, emit profile words.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_LOAD;
            count      <= '0;
            sum        <= '0;
            prefix     <= '0;
            idx        <= '0;
            series_n   <= '0;
            series_sum <= '0;
            err_trunc  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_index  <= '0;
            out_last   <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        count <= count_nxt;
                        sum   <= sum_nxt;
                        if (in_last || (count_nxt == CNT_W'(MAX_N))) begin
                            state      <= ST_PRIME;
                            series_n   <= count_nxt;
                            series_sum <= sum_nxt;
                            if (!in_last)
                                err_trunc <= 1'b1;
                        end
                    end
                end
                ST_PRIME: begin
                    idx    <= '0;
                    prefix <= '0;
                    state  <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (load_word) begin
                        out_valid <= 1'b1;
                        out_data  <= word_pos - word_neg;
                        out_index <= idx_nxt;
                        out_last  <= (idx_nxt == series_n);
                        idx       <= idx_nxt;
                        prefix    <= prefix_nxt;
                    end else if (done_word) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        state     <= ST_LOAD;
                        count     <= '0;
                        sum       <= '0;
                        prefix    <= '0;
                        idx       <= '0;
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_mfdfa_profile.sv
// Randomized self-checking bench for mfdfa_profile against a series-level model.
module tb_mfdfa_profile;
    import mfdfa_pkg::*;

    localparam int DW   = 16;
    localparam int N_A  = 512;
    localparam int CW_A = cnt_w(N_A);
    localparam int PW_A = prof_w(DW, CW_A);
    localparam int N_B  = 4;
    localparam int CW_B = cnt_w(N_B);
    localparam int PW_B = prof_w(DW, CW_B);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          sel;
    logic          in_valid;
    logic          in_last;
    logic          out_ready;
    logic [DW-1:0] in_data;

    logic               a_in_ready, a_out_valid, a_out_last, a_err, a_busy;
    logic [PW_A-1:0]    a_out_data;
    logic [CW_A-1:0]    a_out_index, a_series_n;
    logic [DW+CW_A-1:0] a_series_sum;
    logic               b_in_ready, b_out_valid, b_out_last, b_err, b_busy;
    logic [PW_B-1:0]    b_out_data;
    logic [CW_B-1:0]    b_out_index, b_series_n;
    logic [DW+CW_B-1:0] b_series_sum;

    mfdfa_profile #(.DATA_W(DW), .MAX_N(N_A)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && !sel), .in_ready(a_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(a_out_valid), .out_ready(out_ready && !sel), .out_data(a_out_data),
        .out_index(a_out_index), .out_last(a_out_last), .series_n(a_series_n),
        .series_sum(a_series_sum), .err_trunc(a_err), .busy(a_busy)
    );

    mfdfa_profile #(.DATA_W(DW), .MAX_N(N_B)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && sel), .in_ready(b_in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(b_out_valid), .out_ready(out_ready && sel), .out_data(b_out_data),
        .out_index(b_out_index), .out_last(b_out_last), .series_n(b_series_n),
        .series_sum(b_series_sum), .err_trunc(b_err), .busy(b_busy)
    );

    logic               o_in_ready, o_valid, o_last, o_err, o_busy;
    logic signed [63:0] o_data;
    logic [63:0]        o_index, o_n, o_sum;

    always_comb begin
        o_in_ready = sel ? b_in_ready  : a_in_ready;
        o_valid    = sel ? b_out_valid : a_out_valid;
        o_last     = sel ? b_out_last  : a_out_last;
        o_err      = sel ? b_err       : a_err;
        o_busy     = sel ? b_busy      : a_busy;
        o_data     = sel ? 64'($signed(b_out_data)) : 64'($signed(a_out_data));
        o_index    = sel ? 64'(b_out_index)  : 64'(a_out_index);
        o_n        = sel ? 64'(b_series_n)   : 64'(a_series_n);
        o_sum      = sel ? 64'(b_series_sum) : 64'(a_series_sum);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        longint idx;
        longint val;
        longint last;
        longint n;
        longint sum;
    } word_t;

    logic [DW-1:0] stim_d[$];
    bit            stim_l[$];
    longint        pend[$];
    word_t         exp_q[$];

    // Model: a series closes on in_last or on reaching max_n samples; its
    // profile is Yn[k] = N*P_k - k*S computed directly from the samples.
    task automatic push(input int unsigned d, input bit l, input int max_n);
        longint n, s, p;
        stim_d.push_back(DW'(d));
        stim_l.push_back(l);
        pend.push_back(longint'(d));
        if (l || pend.size() == max_n) begin
            n = pend.size();
            s = 0;
            p = 0;
            foreach (pend[i]) s += pend[i];
            for (int k = 1; k <= n; k++) begin
                p += pend[k-1];
                exp_q.push_back('{k, n * p - k * s, (k == n) ? 1 : 0, n, s});
            end
            pend.delete();
        end
    endtask

    // ready_mode: 0 always ready, 1 random, 2 fixed 1,0,0,1,0,1 pattern.
    task automatic run(input int ready_mode, input int valid_pct, input int stop_hs, input int budget);
        int cyc = 0;
        int hs  = 0;
        int pat = 0;
        bit in_acc = 0;
        bit rdy_pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        while ((stim_d.size() > 0 || in_valid || exp_q.size() > 0) && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (in_acc) begin
                in_valid = 1'b0;
                in_acc   = 1'b0;
            end
            if (!in_valid && stim_d.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
                in_valid = 1'b1;
                in_data  = stim_d.pop_front();
                in_last  = stim_l.pop_front();
            end
            in_acc = in_valid && o_in_ready;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = o_valid ? rdy_pat[pat % 6] : 1'b0;
            endcase
            if (o_valid) begin
                pat++;
                if (exp_q.size() == 0) begin
                    check("extra_word_index", longint'(o_index), 0);
                end else begin
                    check("out_index",  longint'(o_index), exp_q[0].idx);
                    check("out_data",   o_data,            exp_q[0].val);
                    check("out_last",   longint'(o_last),  exp_q[0].last);
                    check("series_n",   longint'(o_n),     exp_q[0].n);
                    check("series_sum", longint'(o_sum),   exp_q[0].sum);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        hs++;
                    end
                end
            end
            if (stop_hs > 0 && hs == stop_hs)
                break;
        end
        if (stop_hs == 0)
            check("drain_left", longint'(exp_q.size() + stim_d.size()), 0);
        else
            check("handshakes_before_stop", hs, stop_hs);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stim_d.delete();
        stim_l.delete();
        pend.delete();
        exp_q.delete();
        @(negedge clk);
        check("rst_out_valid", longint'(o_valid), 0);
        check("rst_in_ready",  longint'(o_in_ready), 1);
        check("rst_busy",      longint'(o_busy), 0);
        check("rst_err_trunc", longint'(o_err), 0);
        check("rst_series_n",  longint'(o_n), 0);
        check("rst_out_data",  o_data, 0);
        rst = 1'b0;
    endtask

    initial begin
        int len;
        sel       = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        do_reset();

        // Basic three-sample series.
        push(10, 0, N_A); push(20, 0, N_A); push(30, 1, N_A);
        run(0, 100, 0, 200);
        check("t1_series_n",   longint'(o_n), 3);
        check("t1_series_sum", longint'(o_sum), 60);
        check("t1_err_trunc",  longint'(o_err), 0);

        // Single-sample series.
        push(5, 1, N_A);
        run(0, 100, 0, 100);
        check("t2_in_ready", longint'(o_in_ready), 1);
        check("t2_busy",     longint'(o_busy), 0);

        // Constant series then a back-to-back pair.
        for (int i = 0; i < 8; i++) push(12000, (i == 7), N_A);
        push(10768, 0, N_A); push(10519, 1, N_A);
        run(0, 100, 0, 300);

        // Backpressure pattern.
        push(10, 0, N_A); push(20, 0, N_A); push(30, 1, N_A);
        run(2, 100, 0, 200);

        // Random series with random valid gaps and random backpressure.
        for (int s = 0; s < 6; s++) begin
            len = $urandom_range(1, 24);
            for (int i = 0; i < len; i++)
                push($urandom_range(0, 65535), (i == len - 1), N_A);
        end
        run(1, 70, 0, 4000);
        check("rand_err_trunc", longint'(o_err), 0);

        // Reset in the middle of emission.
        push(10, 0, N_A); push(20, 0, N_A); push(30, 1, N_A);
        run(0, 100, 1, 200);
        do_reset();
        push(7, 0, N_A); push(9, 1, N_A);
        run(0, 100, 0, 200);

        // MAX_N = 4 instance: exact fill with in_last, then truncation.
        sel = 1'b1;
        @(negedge clk);
        for (int i = 1; i <= 4; i++) push(i, (i == 4), N_B);
        run(0, 100, 0, 200);
        check("b_exact_err_trunc", longint'(o_err), 0);
        for (int i = 1; i <= 6; i++) push(i, 0, N_B);
        run(1, 80, 0, 400);
        check("b_trunc_err_trunc", longint'(o_err), 1);
        check("b_trunc_busy",      longint'(o_busy), 0);
        push(7, 1, N_B);
        run(1, 80, 0, 200);
        check("b_next_series_n", longint'(o_n), 3);
        check("b_err_sticky",    longint'(o_err), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
